// File: rtl/btn_rate_pkg.sv
// ---------------------------------------------------------------------------
// btn_rate_pkg
// Shared definitions for the button-controlled rate counter.
//   deb_state_t     : per-button debounce FSM encoding (IDLE/COUNT/ARMED/HELD)
//   DEF_DEB_THRESH  : default number of ticks before a press is accepted
//   DEF_LONG_THRESH : default number of ticks before a press becomes "long"
//   cnt_bits()      : width needed to hold a tick count up to a given value
// HELD is only reachable when BTN_LONG_PRESS_EN is defined.
// ---------------------------------------------------------------------------
package btn_rate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ARMED = 2'd2,
    ST_HELD  = 2'd3
  } deb_state_t;

  localparam int DEF_DEB_THRESH  = 20;
  localparam int DEF_LONG_THRESH = 250;

  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_rate_counter_if.sv
// ---------------------------------------------------------------------------
// btn_rate_counter_if
// Groups the user-facing signals of btn_rate_counter.
//   en     : count enable (PLL locked)
//   btn_n  : raw buttons, low = pressed
//   led    : active-low LEDs, inverted top counter bits
//   shift  : current step exponent
//   tick   : one-cycle debounce strobe
//   paused : counter frozen by a long press (only with BTN_LONG_PRESS_EN)
// slave = the counter, master = whatever drives it.
// ---------------------------------------------------------------------------
interface btn_rate_counter_if #(
  parameter int LED_COUNT   = 4,
  parameter int SHIFT_WIDTH = 3,
  parameter int NUM_BTN     = 2
);
  logic                   en;
  logic [NUM_BTN-1:0]     btn_n;
  logic [LED_COUNT-1:0]   led;
  logic [SHIFT_WIDTH-1:0] shift;
  logic                   tick;
  logic                   paused;

  modport master (
    output en, btn_n,
    input  led, shift, tick, paused
  );

  modport slave (
    input  en, btn_n,
    output led, shift, tick, paused
  );
endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button: 2-flop synchroniser followed by a tick-paced debounce FSM.
//   clk_50m   : clock
//   rstn      : asynchronous active-low reset
//   tick      : debounce strobe; the FSM only moves on tick cycles
//   btn_n     : raw asynchronous button, low = pressed
//   short_rel : one-cycle pulse when a debounced press is released
//   long_rel  : one-cycle pulse when a long press is released
//               (always 0 unless BTN_LONG_PRESS_EN is defined)
// Macro BTN_LONG_PRESS_EN adds parameter LONG_THRESH and the HELD state.
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_rate_pkg::*;
#(
  parameter int DEB_THRESH  = DEF_DEB_THRESH
`ifdef BTN_LONG_PRESS_EN
  ,parameter int LONG_THRESH = DEF_LONG_THRESH
`endif
) (
  input  logic clk_50m,
  input  logic rstn,
  input  logic tick,
  input  logic btn_n,
  output logic short_rel,
  output logic long_rel
);

`ifdef BTN_LONG_PRESS_EN
  localparam int CMAX = LONG_THRESH;
`else
  localparam int CMAX = DEB_THRESH;
`endif
  localparam int            CW      = cnt_bits(CMAX);
  localparam logic [CW-1:0] DEB_LIM = CW'(DEB_THRESH);
`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_THRESH);
`endif

  // The synchroniser carries the *pressed* polarity so that its reset
  // value (0) means "released" and a held button after reset is seen
  // as a fresh press rather than a leftover one.
  logic [1:0]    sync_reg;
  deb_state_t    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pressed;

  assign pressed = sync_reg[1];

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      sync_reg  <= 2'b00;
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], ~btn_n};
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    short_rel  = 1'b0;
    long_rel   = 1'b0;
    if (tick) begin
      if (!pressed) begin
        // Release from any state: only an accepted press reports anything.
        state_next = ST_IDLE;
        count_next = '0;
        short_rel  = (state_reg == ST_ARMED);
`ifdef BTN_LONG_PRESS_EN
        long_rel   = (state_reg == ST_HELD);
`endif
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_next = ST_COUNT;
            count_next = CW'(1);
          end
          ST_COUNT: begin
            count_next = count_reg + 1'b1;
            if (count_next >= DEB_LIM) state_next = ST_ARMED;
          end
          ST_ARMED: begin
`ifdef BTN_LONG_PRESS_EN
            count_next = count_reg + 1'b1;
            if (count_next >= LONG_LIM) state_next = ST_HELD;
`else
            count_next = count_reg;  // saturate at the accept threshold
`endif
          end
          ST_HELD: begin
`ifdef BTN_LONG_PRESS_EN
            count_next = count_reg;
`else
            // Unreachable without long-press support; recover cleanly.
            state_next = ST_IDLE;
            count_next = '0;
`endif
          end
          default: begin
            state_next = ST_IDLE;
            count_next = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_rate_counter.sv
// ---------------------------------------------------------------------------
// btn_rate_counter
// Free-running counter whose step is 1 << shift; two debounced buttons move
// the step exponent up (btn 0) and down (btn 1). The top LED_COUNT counter
// bits drive active-low LEDs.
//   clk_50m : the only clock, rising edge
//   rstn    : asynchronous active-low reset
//   bus     : btn_rate_counter_if.slave (en, btn_n in; led, shift, tick,
//             paused out)
// Macro BTN_LONG_PRESS_EN: adds parameter LONG_THRESH; a long press on
// btn 0 toggles pause, a long press on btn 1 forces shift to 0.
// Legal only if 2**SHIFT_WIDTH-1 < TICK_BIT < CNT_WIDTH; otherwise large
// steps would never toggle the tick bit and the buttons would go dead.
// ---------------------------------------------------------------------------
module btn_rate_counter
  import btn_rate_pkg::*;
#(
  parameter int LED_COUNT   = 4,
  parameter int CNT_WIDTH   = 30,
  parameter int SHIFT_WIDTH = 3,
  parameter int TICK_BIT    = 16,
  parameter int DEB_THRESH  = DEF_DEB_THRESH,
`ifdef BTN_LONG_PRESS_EN
  parameter int LONG_THRESH = DEF_LONG_THRESH,
`endif
  parameter int NUM_BTN     = 2
) (
  input logic               clk_50m,
  input logic               rstn,
  btn_rate_counter_if.slave bus
);

  localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = '1;

  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [CNT_WIDTH-1:0]   step;
  logic [SHIFT_WIDTH-1:0] shift_reg, shift_next;
  logic                   tick_reg;
  logic                   tick_src, tick_src_q;
  logic                   paused;
  logic                   running;
  logic [NUM_BTN-1:0]     short_rel, long_rel;
  logic                   step_up, step_down;

  assign running = bus.en & ~paused;
  assign step    = CNT_WIDTH'(1) << shift_reg;

`ifdef BTN_LONG_PRESS_EN
  // While paused the counter is frozen, so the debounce time base comes
  // from a small divider instead; otherwise the pause could never be
  // released. It stops with en like the counter does.
  logic                paused_reg, paused_next;
  logic [TICK_BIT:0]   pause_div_reg;

  assign paused   = paused_reg;
  assign tick_src = paused_reg ? pause_div_reg[TICK_BIT] : cnt_reg[TICK_BIT];

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      paused_reg    <= 1'b0;
      pause_div_reg <= '0;
    end else begin
      paused_reg <= paused_next;
      if (paused_reg && bus.en) pause_div_reg <= pause_div_reg + 1'b1;
      else if (!paused_reg)     pause_div_reg <= '0;
    end
  end
`else
  assign paused   = 1'b0;
  assign tick_src = cnt_reg[TICK_BIT];
`endif

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEB_THRESH  (DEB_THRESH)
`ifdef BTN_LONG_PRESS_EN
      ,.LONG_THRESH (LONG_THRESH)
`endif
    ) u_deb (
      .clk_50m   (clk_50m),
      .rstn      (rstn),
      .tick      (tick_reg),
      .btn_n     (bus.btn_n[gi]),
      .short_rel (short_rel[gi]),
      .long_rel  (long_rel[gi])
    );
  end

`ifdef BTN_LONG_PRESS_EN
  assign step_up   = short_rel[0];
  assign step_down = short_rel[1];
`else
  // Without long-press support every accepted release is a step.
  assign step_up   = short_rel[0] | long_rel[0];
  assign step_down = short_rel[1] | long_rel[1];
`endif

  always_comb begin
    shift_next = shift_reg;
`ifdef BTN_LONG_PRESS_EN
    paused_next = paused_reg;
    if (long_rel[0]) paused_next = ~paused_reg;
    if (long_rel[1]) begin
      shift_next = '0;
    end else if (long_rel[0]) begin
      // A long press on btn 0 masks a simultaneous short press on btn 1.
      shift_next = shift_reg;
    end else
`endif
    if (step_up && !step_down) begin
      if (shift_reg != SHIFT_MAX) shift_next = shift_reg + 1'b1;
    end else if (step_down && !step_up) begin
      if (shift_reg != '0) shift_next = shift_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      cnt_reg    <= '0;
      shift_reg  <= '0;
      tick_src_q <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      if (running) cnt_reg <= cnt_reg + step;
      shift_reg  <= shift_next;
      // Rising edge of the tick source, delayed one cycle; a holding
      // counter never produces an edge.
      tick_src_q <= tick_src;
      tick_reg   <= tick_src & ~tick_src_q;
    end
  end

  assign bus.led    = ~cnt_reg[CNT_WIDTH-1 -: LED_COUNT];
  assign bus.shift  = shift_reg;
  assign bus.tick   = tick_reg;
  assign bus.paused = paused;

endmodule

// File: tb/tb_btn_rate_counter.sv
`timescale 1ns/1ps
// Directed bench for btn_rate_counter. SHIFT_WIDTH=1 keeps SHIFT_MAX below
// TICK_BIT=2 so ticks keep coming at every legal step size.
module tb_btn_rate_counter;
  localparam int LED_COUNT   = 4;
  localparam int CNT_WIDTH   = 8;
  localparam int SHIFT_WIDTH = 1;
  localparam int TICK_BIT    = 2;
  localparam int DEB_THRESH  = 3;
`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_THRESH = 6;
  localparam bit LONG_EN     = 1'b1;
`else
  localparam bit LONG_EN     = 1'b0;
`endif

  typedef struct {
    logic [1:0] press;      // buttons held (bit set = pressed)
    int         ticks;      // ticks the press is held
    int         exp_shift;
    logic       exp_paused;
    string      name;
  } vec_t;

  logic clk_50m = 1'b0;
  logic rstn    = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  vec_t vecs [13];

  btn_rate_counter_if #(
    .LED_COUNT(LED_COUNT), .SHIFT_WIDTH(SHIFT_WIDTH), .NUM_BTN(2)
  ) bus ();

  btn_rate_counter #(
    .LED_COUNT  (LED_COUNT),
    .CNT_WIDTH  (CNT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .TICK_BIT   (TICK_BIT),
    .DEB_THRESH (DEB_THRESH),
`ifdef BTN_LONG_PRESS_EN
    .LONG_THRESH(LONG_THRESH),
`endif
    .NUM_BTN    (2)
  ) dut (
    .clk_50m(clk_50m),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns at the falling edge of a cycle in which tick is high.
  task automatic wait_tick(input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk_50m);
      n++;
      if (bus.tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_tick_timeout: got no tick expected one within 64 cycles", name);
    end
  endtask

  task automatic run_press(input vec_t v);
    logic [LED_COUNT-1:0] led_before;
    wait_tick(v.name);            // align: next tick is >= 4 cycles away
    bus.btn_n = ~v.press;
    repeat (v.ticks) wait_tick(v.name);
    bus.btn_n = 2'b11;
    repeat (3) wait_tick(v.name);
    check({v.name, "_shift"}, int'(bus.shift), v.exp_shift);
    check({v.name, "_paused"}, int'(bus.paused), int'(v.exp_paused));
    led_before = bus.led;
    repeat (24) @(negedge clk_50m);
    check({v.name, "_frozen"}, int'(bus.led == led_before), int'(v.exp_paused));
    $display("press %s mask=%b ticks=%0d -> shift=%0d paused=%0d",
             v.name, v.press, v.ticks, bus.shift, bus.paused);
  endtask

  initial begin
    int n_tick;
    logic [7:0] k8;

    vecs[0]  = '{2'b01, 4, 1, 1'b0, "inc"};
    vecs[1]  = '{2'b01, 2, 1, 1'b0, "short_hold0"};
    vecs[2]  = '{2'b01, 4, 1, 1'b0, "sat_max"};
    vecs[3]  = '{2'b11, 4, 1, 1'b0, "both"};
    vecs[4]  = '{2'b10, 4, 0, 1'b0, "dec"};
    vecs[5]  = '{2'b10, 4, 0, 1'b0, "sat_min"};
    vecs[6]  = '{2'b10, 2, 0, 1'b0, "short_hold1"};
    vecs[7]  = '{2'b01, 3, 1, 1'b0, "thresh_exact"};
    vecs[8]  = '{2'b10, 4, 0, 1'b0, "dec_again"};
    vecs[9]  = '{2'b01, 7, LONG_EN ? 0 : 1, LONG_EN, "long0"};
    vecs[10] = '{2'b01, 7, LONG_EN ? 0 : 1, 1'b0, "long0_again"};
    vecs[11] = '{2'b01, 4, 1, 1'b0, "inc_after_long"};
    vecs[12] = '{2'b10, 7, 0, 1'b0, "long1"};

    bus.en    = 1'b0;
    bus.btn_n = 2'b11;
    #3 rstn   = 1'b0;
    repeat (3) @(negedge clk_50m);
    check("rst_led", int'(bus.led), 15);
    check("rst_shift", int'(bus.shift), 0);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_paused", int'(bus.paused), 0);
    $display("reset: led=%h shift=%0d tick=%0d paused=%0d",
             bus.led, bus.shift, bus.tick, bus.paused);

    // Counting from reset: after k edges the counter is k, and the tick
    // appears the cycle after bit 2 first reads 1 (counter 4, 12, ...).
    rstn   = 1'b1;
    bus.en = 1'b1;
    n_tick = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_50m);
      k8 = 8'(k);
      check($sformatf("cnt_led_%0d", k), int'(bus.led), int'(~k8[7:4] & 4'hF));
      check($sformatf("cnt_tick_%0d", k), int'(bus.tick), int'(((k - 1) % 8) == 4));
      if (bus.tick) n_tick++;
    end
    check("tick_count_40", n_tick, 5);
    $display("count: 40 cycles led=%h ticks=%0d", bus.led, n_tick);

    // en low: counter holds at 40 (led ~2) and no ticks appear.
    bus.en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_50m);
      check("hold_led", int'(bus.led), 13);
      check("hold_tick", int'(bus.tick), 0);
    end
    $display("hold: en=0 led=%h", bus.led);
    bus.en = 1'b1;

    for (int i = 0; i < 13; i++) run_press(vecs[i]);

    // Reset in the middle of a press (count=2) with shift=1.
    run_press('{2'b01, 4, 1, 1'b0, "pre_reset"});
    wait_tick("mid_reset");
    bus.btn_n = 2'b10;
    repeat (2) wait_tick("mid_reset");
    rstn = 1'b0;
    repeat (2) @(negedge clk_50m);
    check("midrst_led", int'(bus.led), 15);
    check("midrst_shift", int'(bus.shift), 0);
    check("midrst_tick", int'(bus.tick), 0);
    check("midrst_paused", int'(bus.paused), 0);
    rstn = 1'b1;
    @(negedge clk_50m);
    bus.btn_n = 2'b11;
    repeat (3) wait_tick("after_reset");
    check("after_reset_shift", int'(bus.shift), 0);
    check("after_reset_paused", int'(bus.paused), 0);
    $display("mid-press reset: shift=%0d paused=%0d", bus.shift, bus.paused);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
